// File: rtl/qspi_xfer_sequencer.sv
// QSPI word-transfer sequencer: shift-register strobes, mode-0 SCLK and CS_n; all outputs registered, load one cycle after accept.
// start is taken only while ready (IDLE) and never queued; optional abort input/aborted output under QSPI_XFER_ABORT_EN.
module qspi_xfer_sequencer #(
  parameter int DIV_W        = 8,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       lane_mode,
  input  logic [1:0]       xfer_bytes,
  input  logic [DIV_W-1:0] clk_div,
`ifdef QSPI_XFER_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             load,
  output logic             shift_en,
  output logic             sample_en,
  output logic             use_1_io_lines,
  output logic             use_2_io_lines,
  output logic             use_4_io_lines,
  output logic             qspi_sclk,
  output logic             qspi_cs_n,
  output logic             busy,
  output logic             done
);

  localparam int WAIT_W = 16;
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP_CYC - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CS_SETUP, S_XFER, S_CS_HOLD, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic [DIV_W-1:0]  hp_cnt, hp_n, div_q;
  logic [5:0]        beat_cnt, beat_n, beats_q;
  logic              sclk_n, shift_n, sample_n;
  logic              accept, active_n;
  logic [2:0]        nbytes;
  logic [5:0]        nbits, beats_w;

  assign accept = start && ready;

  // Beats per word: bit count divided by the number of active lanes.
  assign nbytes = {1'b0, xfer_bytes} + 3'd1;
  assign nbits  = {nbytes, 3'b000};
  always_comb begin
    case (lane_mode)
      2'b01:   beats_w = nbits >> 1;
      2'b10:   beats_w = nbits >> 2;
      default: beats_w = nbits;
    endcase
  end

`ifdef QSPI_XFER_ABORT_EN
  logic abort_q, abort_hit;
  assign abort_hit = abort && (state == S_LOAD || state == S_CS_SETUP || state == S_XFER);
`endif

  always_comb begin
    state_n  = state;
    wait_n   = wait_cnt;
    hp_n     = hp_cnt;
    beat_n   = beat_cnt;
    sclk_n   = 1'b0;
    shift_n  = 1'b0;
    sample_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_n = S_LOAD;
      end
      S_LOAD: begin
        state_n = S_CS_SETUP;
        wait_n  = '0;
      end
      S_CS_SETUP: begin
        if (wait_cnt == SETUP_LAST) begin
          state_n = S_XFER;
          hp_n    = '0;
          beat_n  = '0;
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      S_XFER: begin
        sclk_n = qspi_sclk;
        if (hp_cnt == div_q) begin
          hp_n = '0;
          if (!qspi_sclk) begin
            sclk_n   = 1'b1;
            sample_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            beat_n = beat_cnt + 6'd1;
            // The last falling edge ends the word; nothing left to shift.
            if (beat_n == beats_q) begin
              state_n = S_CS_HOLD;
              wait_n  = '0;
            end else begin
              shift_n = 1'b1;
            end
          end
        end else begin
          hp_n = hp_cnt + DIV_W'(1);
        end
      end
      S_CS_HOLD: begin
        if (wait_cnt == HOLD_LAST) state_n = S_DONE;
        else wait_n = wait_cnt + WAIT_W'(1);
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
`ifdef QSPI_XFER_ABORT_EN
    if (abort_hit) begin
      state_n  = S_CS_HOLD;
      wait_n   = '0;
      sclk_n   = 1'b0;
      shift_n  = 1'b0;
      sample_n = 1'b0;
    end
`endif
  end

  assign active_n = (state_n == S_LOAD) || (state_n == S_CS_SETUP) ||
                    (state_n == S_XFER) || (state_n == S_CS_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      hp_cnt         <= '0;
      beat_cnt       <= '0;
      beats_q        <= '0;
      div_q          <= '0;
      ready          <= 1'b1;
      load           <= 1'b0;
      shift_en       <= 1'b0;
      sample_en      <= 1'b0;
      qspi_sclk      <= 1'b0;
      qspi_cs_n      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      use_1_io_lines <= 1'b1;
      use_2_io_lines <= 1'b0;
      use_4_io_lines <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      hp_cnt    <= hp_n;
      beat_cnt  <= beat_n;
      ready     <= (state_n == S_IDLE);
      load      <= (state_n == S_LOAD);
      shift_en  <= shift_n;
      sample_en <= sample_n;
      qspi_sclk <= sclk_n;
      qspi_cs_n <= !active_n;
      busy      <= active_n;
      done      <= (state_n == S_DONE);
      if (accept) begin
        beats_q        <= beats_w;
        div_q          <= clk_div;
        use_2_io_lines <= (lane_mode == 2'b01);
        use_4_io_lines <= (lane_mode == 2'b10);
        use_1_io_lines <= (lane_mode != 2'b01) && (lane_mode != 2'b10);
      end
    end
  end

`ifdef QSPI_XFER_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_q <= 1'b0;
      aborted <= 1'b0;
    end else begin
      if (accept) abort_q <= 1'b0;
      else if (abort_hit) abort_q <= 1'b1;
      aborted <= (state_n == S_DONE) && abort_q;
    end
  end
`endif

endmodule

// File: tb/tb_qspi_xfer_sequencer.sv
// Bench for qspi_xfer_sequencer: vector table, randomized transfers against a formula model, reset/hold/abort sequences.
module tb_qspi_xfer_sequencer;
  localparam int DIV_W = 8;
  localparam int CS_S  = 2;
  localparam int CS_H  = 2;

  logic clk = 1'b0;
  logic rst, start;
  logic [1:0] lane_mode, xfer_bytes;
  logic [DIV_W-1:0] clk_div;
  logic ready, load, shift_en, sample_en, use_1_io_lines, use_2_io_lines, use_4_io_lines;
  logic qspi_sclk, qspi_cs_n, busy, done;
`ifdef QSPI_XFER_ABORT_EN
  logic abort, aborted;
`endif

  qspi_xfer_sequencer #(.DIV_W(DIV_W), .CS_SETUP_CYC(CS_S), .CS_HOLD_CYC(CS_H)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .lane_mode(lane_mode), .xfer_bytes(xfer_bytes), .clk_div(clk_div),
`ifdef QSPI_XFER_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .load(load), .shift_en(shift_en), .sample_en(sample_en),
    .use_1_io_lines(use_1_io_lines), .use_2_io_lines(use_2_io_lines), .use_4_io_lines(use_4_io_lines),
    .qspi_sclk(qspi_sclk), .qspi_cs_n(qspi_cs_n), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] out_vec();
    return {ready, load, shift_en, sample_en, qspi_sclk, qspi_cs_n, busy, done,
            use_1_io_lines, use_2_io_lines, use_4_io_lines};
  endfunction

  localparam logic [10:0] RESET_VEC = 11'b1000_0100_100;

  function automatic void ref_model(input logic [1:0] lm, input logic [1:0] xb, input logic [7:0] dv,
                                    output int beats, output int lat, output logic [2:0] lanes);
    int nl;
    case (lm)
      2'd1:    begin nl = 2; lanes = 3'b010; end
      2'd2:    begin nl = 4; lanes = 3'b100; end
      default: begin nl = 1; lanes = 3'b001; end
    endcase
    beats = (int'(xb) + 1) * 8 / nl;
    lat   = 1 + CS_S + 2 * (int'(dv) + 1) * beats + CS_H;
  endfunction

  // Runs one transfer and checks every strobe against the expected beat count and latency.
  task automatic run_xfer(input logic [1:0] lm, input logic [1:0] xb, input logic [7:0] dv, input bit mid,
                          input int exp_beats, input int exp_lat, input logic [2:0] exp_lanes, input string tag);
    int loads = 0, samples = 0, shifts = 0, overlap = 0, bad_per = 0, frame_err = 0;
    int done_idx = -1, first_load = -1, first_samp = -1, last_samp = -1;
    logic [2:0] lanes0 = 3'b000;
    int per = 2 * (int'(dv) + 1);
    chk({tag, ".ready_before"}, ready, 1);
    lane_mode = lm; xfer_bytes = xb; clk_div = dv; start = 1'b1;
    for (int k = 0; k < exp_lat + 40 && done_idx < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start  = 1'b0;
        lanes0 = {use_4_io_lines, use_2_io_lines, use_1_io_lines};
        if (mid) begin clk_div = 8'd5; lane_mode = 2'b10; xfer_bytes = 2'd0; end
      end
      if ({use_4_io_lines, use_2_io_lines, use_1_io_lines} !== exp_lanes) frame_err++;
      if (load) begin loads++; if (first_load < 0) first_load = k; end
      if (shift_en) shifts++;
      if (shift_en && sample_en) overlap++;
      if (sample_en) begin
        if (samples > 0 && k - last_samp != per) bad_per++;
        if (samples == 0) first_samp = k;
        last_samp = k;
        samples++;
      end
      if (k < exp_lat && (busy !== 1'b1 || qspi_cs_n !== 1'b0 || ready !== 1'b0 || done !== 1'b0)) frame_err++;
      if (k >= exp_lat - CS_H && qspi_sclk !== 1'b0) frame_err++;
      if (done === 1'b1) begin
        done_idx = k;
        if (qspi_cs_n !== 1'b1 || busy !== 1'b0) frame_err++;
`ifdef QSPI_XFER_ABORT_EN
        if (aborted !== 1'b0) frame_err++;
`endif
      end
    end
    chk({tag, ".loads"}, loads, 1);
    chk({tag, ".load_idx"}, first_load, 0);
    chk({tag, ".lanes"}, lanes0, exp_lanes);
    chk({tag, ".samples"}, samples, exp_beats);
    chk({tag, ".shifts"}, shifts, exp_beats - 1);
    chk({tag, ".first_sample"}, first_samp, 2 + CS_S + int'(dv));
    chk({tag, ".sclk_period"}, bad_per, 0);
    chk({tag, ".overlap"}, overlap, 0);
    chk({tag, ".framing"}, frame_err, 0);
    chk({tag, ".done_latency"}, done_idx, exp_lat);
    @(negedge clk);
    chk({tag, ".done_one_cycle"}, {done, ready}, 2'b01);
  endtask

  typedef struct {
    logic [1:0] lm;
    logic [1:0] xb;
    logic [7:0] dv;
    bit         mid;
    int         beats;
    int         lat;
    logic [2:0] lanes;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int b, l, nd, idx2;
    logic [2:0] ln;
    logic [1:0] rlm, rxb;
    logic [7:0] rdv;
    tbl[0] = '{2'd0, 2'd0, 8'd1, 1'b0,  8,  37, 3'b001};
    tbl[1] = '{2'd2, 2'd3, 8'd0, 1'b0,  8,  21, 3'b100};
    tbl[2] = '{2'd1, 2'd3, 8'd0, 1'b1, 16,  37, 3'b010};
    tbl[3] = '{2'd3, 2'd1, 8'd2, 1'b0, 16, 101, 3'b001};
    tbl[4] = '{2'd1, 2'd0, 8'd3, 1'b0,  4,  37, 3'b010};
    tbl[5] = '{2'd2, 2'd0, 8'd0, 1'b0,  2,   9, 3'b100};

    rst = 1'b1; start = 1'b0; lane_mode = 2'd0; xfer_bytes = 2'd0; clk_div = '0;
`ifdef QSPI_XFER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), RESET_VEC);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_xfer(tbl[i].lm, tbl[i].xb, tbl[i].dv, tbl[i].mid, tbl[i].beats, tbl[i].lat, tbl[i].lanes,
               $sformatf("tbl%0d", i));

    for (int i = 0; i < 16; i++) begin
      rlm = 2'($urandom_range(0, 3));
      rxb = 2'($urandom_range(0, 3));
      rdv = 8'($urandom_range(0, 6));
      ref_model(rlm, rxb, rdv, b, l, ln);
      run_xfer(rlm, rxb, rdv, 1'b0, b, l, ln, $sformatf("rnd%0d", i));
    end

    // start held through DONE: 2 beats, done at 9, re-accept once ready returns.
    lane_mode = 2'd2; xfer_bytes = 2'd0; clk_div = 8'd0; start = 1'b1;
    nd = 0; idx2 = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (load && k > 0 && idx2 < 0) idx2 = k;
      if (load) nd++;
    end
    start = 1'b0;
    chk("hold.loads", nd, 2);
    chk("hold.second_load", idx2, 11);
    nd = 0;
    for (int k = 0; k < 40 && nd == 0; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("hold.second_done", nd, 1);
    repeat (2) @(negedge clk);

    // Reset asserted in the middle of XFER.
    lane_mode = 2'd1; xfer_bytes = 2'd3; clk_div = 8'd2; start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    chk("midrst.in_xfer", {busy, qspi_cs_n}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.outputs", out_vec(), RESET_VEC);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst.no_done", nd, 0);
    chk("midrst.ready", ready, 1);

`ifdef QSPI_XFER_ABORT_EN
    // Abort sampled at a falling-edge slot: sclk and shift_en must stay low, done+aborted 2 cycles later.
    lane_mode = 2'd0; xfer_bytes = 2'd0; clk_div = 8'd1; start = 1'b1;
    nd = -1; idx2 = 0;
    for (int k = 0; k < 50 && nd < 0; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 7) begin
        abort = 1'b0;
        chk("abort.sclk_shift", {qspi_sclk, shift_en}, 2'b00);
      end
      if (k == 6) abort = 1'b1;
      if (done) begin nd = k; idx2 = aborted; end
    end
    chk("abort.done_idx", nd, 9 + CS_H - 2);
    chk("abort.aborted", idx2, 1);
    repeat (2) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/qspi_xfer_sequencer.md
# qspi_xfer_sequencer

Transfer sequencer and SCLK generator that sits directly upstream of the QSPI multi-lane output shift register. It accepts one word-transfer request from the AHB-side controller and generates the register's load and shift-enable strobes. It also drives the QSPI serial clock and chip select, and produces a receive-sample strobe for the capture path. Operation is SPI mode 0: SCLK idles low, data shifts on the falling edge, and data is sampled on the rising edge.

## Interface
- DIV_W, 8: width of the clock divider field.
- CS_SETUP_CYC, 2: clk cycles between CS_n falling and the first SCLK edge (minimum 1).
- CS_HOLD_CYC, 2: clk cycles between the last SCLK falling edge and CS_n rising (minimum 1).
- clk  input  1  system clock (HCLK domain). One clock only.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  transfer request; accepted on a clk edge where start && ready.
- ready  output  1  high only in IDLE.
- lane_mode  input  2  00 = single, 01 = dual, 10 = quad, 11 = reserved (treated as single).
- xfer_bytes  input  2  transfer length minus 1 (0 = 8 bits … 3 = 32 bits, MSB-aligned in the word).
- clk_div  input  DIV_W  SCLK half-period minus 1, in clk cycles.
- load  output  1  one-cycle strobe to the shift register.
- shift_en  output  1  one-cycle strobe, coincident with the SCLK falling edge.
- sample_en  output  1  one-cycle strobe, coincident with the SCLK rising edge.
- use_1_io_lines, use_2_io_lines, use_4_io_lines  output  1 each  one-hot lane select, latched at accept.
- qspi_sclk  output  1  serial clock.
- qspi_cs_n  output  1  chip select, active low.
- busy  output  1  high from the accept edge until done.
- done  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, CS_SETUP, XFER, CS_HOLD, DONE.
- On accept, latch lane_mode, xfer_bytes and clk_div. Later input changes are ignored until the next accept.
- Beats = ((xfer_bytes+1)·8) >> lane_shift, where lane_shift = 0/1/2 for single/dual/quad. Range is 2..32 beats; the beat counter is 6 bits.
- IDLE: when start && ready, go to LOAD.
- LOAD: lasts 1 cycle with load=1 and cs_n=0, then go to CS_SETUP.
- CS_SETUP: lasts CS_SETUP_CYC cycles, then go to XFER with sclk=0 and the half-period counter at 0.
- XFER:
  - The half-period counter counts 0..clk_div. At terminal count the counter wraps and sclk toggles.
  - Toggle 0→1: sample_en=1.
  - Toggle 1→0: increment the beat counter. If this is not the final beat, shift_en=1.
  - On the final falling edge, shift_en stays 0 and the FSM goes to CS_HOLD.
- CS_HOLD: lasts CS_HOLD_CYC cycles with sclk=0, then cs_n goes to 1 and the FSM goes to DONE.
- DONE: lasts 1 cycle with done=1, then go to IDLE.
- Lane mode 11 behaves exactly as single, so use_1_io_lines=1.
- A start that is asserted while ready=0 (including the DONE cycle) is ignored, not queued.

## Timing
- Reset values of all outputs:
  - ready=1.
  - load=0, shift_en=0, sample_en=0.
  - qspi_sclk=0, qspi_cs_n=1.
  - busy=0, done=0.
  - use_1_io_lines=1, use_2_io_lines=0, use_4_io_lines=0.
  - Reset state is IDLE.
- All outputs are registered. The load strobe appears in the cycle immediately after the accept edge, and busy rises in that same cycle.
- The done-high cycle occurs exactly 1 + CS_SETUP_CYC + 2·(clk_div+1)·beats + CS_HOLD_CYC cycles after the accept edge.
- SCLK period is 2·(clk_div+1) clk cycles. clk_div=0 gives SCLK = clk/2.
- shift_en and sample_en are never high in the same cycle. Exactly beats−1 shift_en pulses and beats sample_en pulses occur per transfer.
- Reset asserted mid-transfer: on the next edge the block returns to reset values, with cs_n=1 and sclk=0 immediately. No done pulse is produced.

## Configuration
- Macro: QSPI_XFER_ABORT_EN.
- When defined, the block adds an input port `abort` (1 bit). Abort sampled high in LOAD, CS_SETUP or XFER forces the following on the next edge:
  - sclk=0 and shift_en=0;
  - entry to CS_HOLD, which runs its normal CS_HOLD_CYC cycles;
  - DONE, with done=1, and an added output `aborted`=1 in the same cycle.
- Abort during CS_HOLD, DONE or IDLE is ignored.
- When not defined, neither port exists and transfers always run to completion.

## Test plan
- Reset: hold rst for 3 cycles → all outputs at their reset values and ready=1.
- Single lane, xfer_bytes=0, clk_div=1, default params → 8 sample_en pulses, 7 shift_en pulses, SCLK period 4 cycles, done 37 cycles after accept.
- Quad lane, xfer_bytes=3, clk_div=0 → use_4_io_lines=1, 8 beats, 7 shift_en pulses, done 1+2+16+2 = 21 cycles after accept.
- Dual lane with clk_div changed mid-transfer from 0 to 5 → latched divider kept (SCLK period 2), 16 beats for xfer_bytes=3.
- Start held high through DONE → exactly one transfer per IDLE acceptance. A second load occurs only in the cycle after the next accept edge.
- Reset asserted in the middle of XFER → cs_n=1 and sclk=0 on the next edge, and no done pulse. With QSPI_XFER_ABORT_EN, abort in XFER → done and aborted high together after CS_HOLD_CYC cycles.
